// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request packet type and core memory port interface
package mem_responder_pkg;
  localparam logic [1:0] REQ_READ  = 2'd0;
  localparam logic [1:0] REQ_WRITE = 2'd1;

  typedef struct packed {
    logic        vld;
    logic [1:0]  req_type;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  access_id;
  } request_t;
endpackage

interface mem_responder_if;
  import mem_responder_pkg::*;

  request_t core_req;
  request_t core_rsp;
  logic     fifo_full;
  logic     overflow_err;
  logic     busy;

  modport master (output core_req, input core_rsp, fifo_full, overflow_err, busy);
  modport slave  (input core_req, output core_rsp, fifo_full, overflow_err, busy);
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - queued fixed-latency memory responder; MEM_RESPONDER_WRITE_ACK_EN enables write acks
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH      = 1024,
  parameter int FIFO_DEPTH     = 8,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave port
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ACCESS_LATENCY + 1);
`ifdef MEM_RESPONDER_WRITE_ACK_EN
  localparam bit WRITE_ACK = 1'b1;
`else
  localparam bit WRITE_ACK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  request_t      req_q;
  request_t      rsp_q;
  request_t      head;
  request_t      fifo_mem [FIFO_DEPTH];
  logic [63:0]   mem [MEM_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          overflow_q;
  logic [AW-1:0] idx;
  logic          is_write;
  logic          access_done;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          push_ok;

  assign idx         = req_q.addr[3 +: AW];
  assign is_write    = (req_q.req_type == REQ_WRITE);
  assign access_done = (state == ACCESS) && (cnt == '0);
  assign empty       = (count == '0);
  assign full        = (count == (PW+1)'(FIFO_DEPTH));
  assign head        = fifo_mem[rd_ptr];
  assign push        = port.core_req.vld;
  // A posted write frees the FSM at the end of ACCESS, so it may pop there too.
  assign pop         = !empty && ((state == IDLE) || (state == RESPOND) ||
                                  (access_done && is_write && !WRITE_ACK));
  assign push_ok     = push && (!full || pop);

  assign port.core_rsp     = rsp_q;
  assign port.fifo_full    = full;
  assign port.overflow_err = overflow_q;
  assign port.busy         = (state != IDLE) || !empty;

  // Storage arrays are never reset; only the pointers qualify their contents.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= port.core_req;
    if (access_done && is_write) mem[idx] <= req_q.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_q      <= '0;
      rsp_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push && full && !pop) overflow_q <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase

      rsp_q <= '0;
      case (state)
        IDLE: begin
          if (pop) begin
            req_q <= head;
            cnt   <= CW'(ACCESS_LATENCY - 1);
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (is_write && !WRITE_ACK) begin
            if (pop) begin
              req_q <= head;
              cnt   <= CW'(ACCESS_LATENCY - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            rsp_q.vld       <= 1'b1;
            rsp_q.req_type  <= req_q.req_type;
            rsp_q.addr      <= req_q.addr;
            rsp_q.access_id <= req_q.access_id;
            rsp_q.data      <= is_write ? req_q.data : mem[idx];
            state           <= RESPOND;
          end
        end
        RESPOND: begin
          if (pop) begin
            req_q <= head;
            cnt   <= CW'(ACCESS_LATENCY - 1);
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
